replay_ctrl: RTL

- Parametrised successor to the single-lane register-replay controller for the fault-tolerant core cluster.
- On an error from any of NUM_CH redundant lanes, it latches which lanes faulted and sweeps register addresses FIRST_ADDR..LAST_ADDR. Each address is presented under a valid/ready handshake so the register-file copy logic can stall the sweep.
- Errors during a sweep trigger bounded retries. A majority fault or retry exhaustion raises a sticky fatal flag.

---
 rtl/replay_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/replay_ctrl.sv
// Register-replay controller for redundant lanes.
// On a lane error it latches the faulty lanes and sweeps FIRST_ADDR..LAST_ADDR under a
// valid/ready handshake so the copy logic can stall. Errors during a sweep restart it, up to
// MAX_RETRY times. Loss of a healthy majority or retry exhaustion is fatal until reset.
module replay_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned FIRST_ADDR = 0,
  parameter int unsigned LAST_ADDR  = 2**ADDR_WIDTH - 1,
  parameter int unsigned MAX_RETRY  = 2,
  localparam int unsigned CntW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [NUM_CH-1:0]     error_i,
  output logic                  replay_valid_o,
  input  logic                  replay_ready_i,
  output logic [ADDR_WIDTH-1:0] replay_addr_o,
  output logic [NUM_CH-1:0]     replay_mask_o,
  output logic [CntW-1:0]       retry_cnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fatal_o
);

  localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(FIRST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [CntW-1:0]       MaxRetry  = CntW'(MAX_RETRY);
  // More faulty lanes than this leaves no healthy majority to copy from.
  localparam int unsigned           MaxFaulty = (NUM_CH - 1) / 2;

  typedef enum logic [1:0] {
    StIdle,
    StReplay,
    StFatal
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [CntW-1:0]       retry_q, retry_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fatal_q, fatal_d;

  logic [NUM_CH-1:0]     mask_next;
  logic                  any_err;
  logic                  majority_lost;
  logic                  xfer;
  logic                  last_addr;

  function automatic int unsigned popcount(input logic [NUM_CH-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

  // Decode of the inputs against the current registered state.
  always_comb begin
    mask_next     = mask_q | error_i;
    any_err       = |error_i;
    majority_lost = popcount(mask_next) > MaxFaulty;
    xfer          = valid_q && replay_ready_i;
    last_addr     = (addr_q == LastAddr);
  end

  // Next-state and next-output computation; every output comes straight from a register.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    retry_d = retry_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fatal_d = fatal_q;

    unique case (state_q)
      StIdle: begin
        if (any_err) begin
          if (majority_lost) begin
            state_d = StFatal;
            mask_d  = mask_next;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            fatal_d = 1'b1;
          end else begin
            state_d = StReplay;
            mask_d  = error_i;
            addr_d  = FirstAddr;
            retry_d = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end

      StReplay: begin
        // An error outranks a same-cycle handshake, even the final one.
        if (any_err) begin
          if (majority_lost || (retry_q == MaxRetry)) begin
            state_d = StFatal;
            mask_d  = mask_next;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            fatal_d = 1'b1;
          end else begin
            mask_d  = mask_next;
            addr_d  = FirstAddr;
            retry_d = retry_q + CntW'(1);
            valid_d = 1'b1;
          end
        end else if (xfer) begin
          if (last_addr) begin
            state_d = StIdle;
            addr_d  = FirstAddr;
            mask_d  = '0;
            retry_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Only reached below LastAddr, so the increment cannot wrap.
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end

      StFatal: begin
        // Sticky: everything holds until reset.
        state_d = StFatal;
      end

      default: begin
        state_d = StFatal;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        fatal_d = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= FirstAddr;
      mask_q  <= '0;
      retry_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
      fatal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fatal_q <= fatal_d;
    end
  end

  assign replay_valid_o = valid_q;
  assign replay_addr_o  = addr_q;
  assign replay_mask_o  = mask_q;
  assign retry_cnt_o    = retry_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign fatal_o        = fatal_q;

`ifndef SYNTHESIS
  // Valid is only ever offered while a sweep is in progress.
  a_valid_busy: assert property (@(posedge clk) disable iff (rst_i) valid_q == busy_q);
  // Fatal never clears on its own.
  a_fatal_sticky: assert property (@(posedge clk) disable iff (rst_i) fatal_q |=> fatal_q);
`endif

endmodule
